// File: rtl/uhf_sram_pkg.sv
// Shared types and constants for the UHF framer SRAM APB master.
// Grant encoding equals the PWRITE value of the granted transfer.
package uhf_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam int ERR_PSLVERR = 0;
   localparam int ERR_TIMEOUT = 1;

   localparam logic GRANT_WR = 1'b1;
   localparam logic GRANT_RD = 1'b0;

endpackage

// File: rtl/uhf_sram_rr_arbiter.sv
// Two-way alternating arbiter between the write and read requesters.
// last_grant only moves when the master actually accepts a grant.
module uhf_sram_rr_arbiter
   import uhf_sram_pkg::*;
(
   input  logic i_PCLK,
   input  logic i_Reset_all,
   input  logic wr_req,
   input  logic rd_req,
   input  logic accept,
   output logic grant_valid,
   output logic grant_dir
);

   logic last_grant_q;

   // A lone request always wins; a tie goes to whoever did not win last.
   always_comb begin
      grant_valid = wr_req | rd_req;
      if (wr_req && rd_req) begin
         grant_dir = ~last_grant_q;
      end else if (wr_req) begin
         grant_dir = GRANT_WR;
      end else begin
         grant_dir = GRANT_RD;
      end
   end

   always_ff @(posedge i_PCLK or negedge i_Reset_all) begin
      if (!i_Reset_all) begin
         last_grant_q <= GRANT_RD;
      end else if (accept && grant_valid) begin
         last_grant_q <= grant_dir;
      end
   end

endmodule

// File: rtl/uhf_sram_apb_master.sv
// APB3 master serving one write and one read requester against the fabric SRAM.
// One transfer at a time, PREADY wait-state timeout, sticky error status.
module uhf_sram_apb_master
   import uhf_sram_pkg::*;
#(
   parameter int                 PADDR_W        = 20,
   parameter int                 DATA_W         = 8,
   parameter int                 PTR_W          = 13,
   parameter logic [PADDR_W-1:0] SRAM_BASE      = '0,
   parameter int                 TIMEOUT_CYCLES = 16
) (
   input  logic               i_PCLK,
   input  logic               i_Reset_all,
   input  logic               i_wr_req,
   input  logic [PTR_W-1:0]   i_wr_ptr,
   input  logic [DATA_W-1:0]  i_wr_data,
   input  logic               i_rd_req,
   input  logic [PTR_W-1:0]   i_rd_ptr,
   input  logic               i_err_clr,
   output logic [PADDR_W-1:0] o_PADDR_SRAM,
   output logic               o_PSEL_SRAM,
   output logic               o_PENABLE_SRAM,
   output logic               o_PWRITE_SRAM,
   output logic [DATA_W-1:0]  o_PWDATA_SRAM,
   input  logic [DATA_W-1:0]  i_PRDATA_SRAM,
   input  logic               i_PREADY_SRAM,
   input  logic               i_PSLVERR_SRAM,
   output logic               o_busy,
   output logic               o_wr_done,
   output logic               o_rd_done,
   output logic [DATA_W-1:0]  o_rd_data,
   output logic               o_err_pulse,
   output logic [1:0]         o_err_status
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   if (PTR_W > PADDR_W) begin : g_ptr_w_check
      $error("PTR_W must not exceed PADDR_W");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // Request/done handshake: a requester raises req with ptr/data stable and
   // holds it until its done pulse; the done cycle is IDLE, so a req still high
   // there is granted again on the next edge and must be dropped to avoid a repeat.
   state_t             state_q, state_d;
   logic               grant_valid, grant_dir, grant_accept;
   logic               timeout_hit, xfer_end;
   logic [CNT_W-1:0]   wait_cnt_q;
   logic [PADDR_W-1:0] addr_d;
   logic               psel_d, penable_d, wr_done_d, rd_done_d, err_pulse_d;
   logic [1:0]         new_err, err_status_d;
   logic [DATA_W-1:0]  rd_data_d;

   uhf_sram_rr_arbiter u_arb (
      .i_PCLK      (i_PCLK),
      .i_Reset_all (i_Reset_all),
      .wr_req      (i_wr_req),
      .rd_req      (i_rd_req),
      .accept      (grant_accept),
      .grant_valid (grant_valid),
      .grant_dir   (grant_dir)
   );

   assign grant_accept = (state_q == ST_IDLE) && grant_valid;
   assign timeout_hit  = (state_q == ST_ACCESS) && !i_PREADY_SRAM &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign xfer_end     = (state_q == ST_ACCESS) && (i_PREADY_SRAM || timeout_hit);
   assign addr_d       = SRAM_BASE + PADDR_W'(grant_dir == GRANT_WR ? i_wr_ptr : i_rd_ptr);

   always_ff @(posedge i_PCLK or negedge i_Reset_all) begin
      if (!i_Reset_all) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (grant_valid) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (xfer_end) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; PWRITE doubles as the latched direction.
   always_comb begin
      psel_d                = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d             = (state_d == ST_ACCESS);
      wr_done_d             = xfer_end && (o_PWRITE_SRAM == GRANT_WR);
      rd_done_d             = xfer_end && (o_PWRITE_SRAM == GRANT_RD);
      new_err               = 2'b00;
      new_err[ERR_PSLVERR]  = xfer_end && i_PREADY_SRAM && i_PSLVERR_SRAM;
      new_err[ERR_TIMEOUT]  = timeout_hit;
      err_pulse_d           = |new_err;
      err_status_d          = (i_err_clr ? 2'b00 : o_err_status) | new_err;
      rd_data_d             = o_rd_data;
      if (rd_done_d && i_PREADY_SRAM) begin
         rd_data_d = i_PRDATA_SRAM;
      end
   end

   always_ff @(posedge i_PCLK or negedge i_Reset_all) begin
      if (!i_Reset_all) begin
         o_PADDR_SRAM   <= '0;
         o_PSEL_SRAM    <= 1'b0;
         o_PENABLE_SRAM <= 1'b0;
         o_PWRITE_SRAM  <= 1'b0;
         o_PWDATA_SRAM  <= '0;
         o_busy         <= 1'b0;
         o_wr_done      <= 1'b0;
         o_rd_done      <= 1'b0;
         o_rd_data      <= '0;
         o_err_pulse    <= 1'b0;
         o_err_status   <= 2'b00;
         wait_cnt_q     <= '0;
      end else begin
         o_PSEL_SRAM    <= psel_d;
         o_PENABLE_SRAM <= penable_d;
         o_busy         <= psel_d;
         o_wr_done      <= wr_done_d;
         o_rd_done      <= rd_done_d;
         o_rd_data      <= rd_data_d;
         o_err_pulse    <= err_pulse_d;
         o_err_status   <= err_status_d;
         if (grant_accept) begin
            o_PADDR_SRAM  <= addr_d;
            o_PWRITE_SRAM <= grant_dir;
            o_PWDATA_SRAM <= i_wr_data;
         end
         if (state_q == ST_SETUP) begin
            wait_cnt_q <= '0;
         end else if ((state_q == ST_ACCESS) && !i_PREADY_SRAM) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uhf_sram_apb_master.sv
// Directed bench for uhf_sram_apb_master: a default-parameter instance and one
// with SRAM_BASE=0x01000, TIMEOUT_CYCLES=4 driven from shared stimulus.
module tb_uhf_sram_apb_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_req = 1'b0, wr_req_a = 1'b0, rd_req = 1'b0, rd_req_a = 1'b0;
   logic [12:0] wr_ptr = '0, rd_ptr = '0;
   logic [7:0]  wr_data = '0, prdata = '0;
   logic        err_clr = 1'b0, pready = 1'b1, pslverr = 1'b0;
   logic        pready_a = 1'b1, pslverr_a = 1'b0;

   logic [19:0] paddr, paddr_a;
   logic        psel, penable, pwrite, busy, wr_done, rd_done, err_pulse;
   logic        psel_a, penable_a, pwrite_a, busy_a, wr_done_a, rd_done_a, err_pulse_a;
   logic [7:0]  pwdata, rd_data, pwdata_a, rd_data_a;
   logic [1:0]  err_status, err_status_a;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [7:0]  exp_q[$];
   logic        exp_dir_q[$];

   always #5 clk = ~clk;

   uhf_sram_apb_master u_dut_a (
      .i_PCLK(clk), .i_Reset_all(rst_n),
      .i_wr_req(wr_req_a), .i_wr_ptr(wr_ptr), .i_wr_data(wr_data),
      .i_rd_req(rd_req_a), .i_rd_ptr(rd_ptr), .i_err_clr(err_clr),
      .o_PADDR_SRAM(paddr_a), .o_PSEL_SRAM(psel_a), .o_PENABLE_SRAM(penable_a),
      .o_PWRITE_SRAM(pwrite_a), .o_PWDATA_SRAM(pwdata_a), .i_PRDATA_SRAM(prdata),
      .i_PREADY_SRAM(pready_a), .i_PSLVERR_SRAM(pslverr_a),
      .o_busy(busy_a), .o_wr_done(wr_done_a), .o_rd_done(rd_done_a),
      .o_rd_data(rd_data_a), .o_err_pulse(err_pulse_a), .o_err_status(err_status_a)
   );

   uhf_sram_apb_master #(.SRAM_BASE(20'h01000), .TIMEOUT_CYCLES(4)) u_dut (
      .i_PCLK(clk), .i_Reset_all(rst_n),
      .i_wr_req(wr_req), .i_wr_ptr(wr_ptr), .i_wr_data(wr_data),
      .i_rd_req(rd_req), .i_rd_ptr(rd_ptr), .i_err_clr(err_clr),
      .o_PADDR_SRAM(paddr), .o_PSEL_SRAM(psel), .o_PENABLE_SRAM(penable),
      .o_PWRITE_SRAM(pwrite), .o_PWDATA_SRAM(pwdata), .i_PRDATA_SRAM(prdata),
      .i_PREADY_SRAM(pready), .i_PSLVERR_SRAM(pslverr),
      .o_busy(busy), .o_wr_done(wr_done), .o_rd_done(rd_done),
      .o_rd_data(rd_data), .o_err_pulse(err_pulse), .o_err_status(err_status)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests_run++;
      if ({paddr, psel, penable, pwrite, pwdata, busy, wr_done, rd_done, rd_data, err_pulse, err_status} !== '0) begin
         tests_failed++; $display("FAIL reset_outputs_b: got paddr=%h psel=%b busy=%b status=%b, all zero required", paddr, psel, busy, err_status);
      end
      tests_run++;
      if ({paddr_a, psel_a, penable_a, pwrite_a, pwdata_a, busy_a, wr_done_a, rd_done_a, rd_data_a, err_pulse_a, err_status_a} !== '0) begin
         tests_failed++; $display("FAIL reset_outputs_a: got paddr=%h psel=%b busy=%b, all zero required", paddr_a, psel_a, busy_a);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_zero_wait();
      pready = 1'b1; wr_ptr = 13'h005; wr_data = 8'hA5;
      wr_req = 1'b1; wr_req_a = 1'b1;
      tick();
      tests_run++;
      if (paddr_a !== 20'h00005 || {psel_a, penable_a, pwrite_a} !== 3'b101) begin
         tests_failed++; $display("FAIL wr_setup_a: got paddr=%h sel/en/wr=%b%b%b, need 00005 101", paddr_a, psel_a, penable_a, pwrite_a);
      end
      tests_run++;
      if (paddr !== 20'h01005 || {psel, penable, pwrite, busy} !== 4'b1011 || pwdata !== 8'hA5) begin
         tests_failed++; $display("FAIL wr_setup_b: got paddr=%h pwdata=%h sel/en/wr/busy=%b%b%b%b, need 01005 a5 1011", paddr, pwdata, psel, penable, pwrite, busy);
      end
      wr_req = 1'b0; wr_req_a = 1'b0;
      tick();
      tests_run++;
      if ({psel, penable, wr_done} !== 3'b110 || paddr !== 20'h01005) begin
         tests_failed++; $display("FAIL wr_access: got sel/en/done=%b%b%b paddr=%h, need 110 01005", psel, penable, wr_done, paddr);
      end
      tick();
      tests_run++;
      if ({wr_done, wr_done_a, err_pulse, psel, penable, busy} !== 6'b110000) begin
         tests_failed++; $display("FAIL wr_done: got done/done_a/err/sel/en/busy=%b%b%b%b%b%b, need 110000", wr_done, wr_done_a, err_pulse, psel, penable, busy);
      end
      tick();
      tests_run++;
      if ({wr_done, wr_done_a, psel, psel_a} !== 4'b0000) begin
         tests_failed++; $display("FAIL wr_done_single_pulse: got done/done_a/sel/sel_a=%b%b%b%b, need 0000", wr_done, wr_done_a, psel, psel_a);
      end
   endtask

   task automatic test_read_waits();
      pready = 1'b0; prdata = 8'h3C; rd_ptr = 13'h1FFF;
      exp_q.push_back(8'h3C);
      rd_req = 1'b1;
      tick();
      tests_run++;
      if (paddr !== 20'h02FFF || {psel, penable, pwrite} !== 3'b100) begin
         tests_failed++; $display("FAIL rd_setup: got paddr=%h sel/en/wr=%b%b%b, need 02fff 100", paddr, psel, penable, pwrite);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if ({psel, penable, busy, rd_done} !== 4'b1110) begin
            tests_failed++; $display("FAIL rd_wait_%0d: got sel/en/busy/done=%b%b%b%b, need 1110", i, psel, penable, busy, rd_done);
         end
      end
      pready = 1'b1;
      tick();
      tests_run++;
      if ({rd_done, err_pulse, psel} !== 3'b100 || rd_data !== exp_q.pop_front()) begin
         tests_failed++; $display("FAIL rd_done: got done/err/sel=%b%b%b rd_data=%h, need 100 3c", rd_done, err_pulse, psel, rd_data);
      end
      rd_req = 1'b0;
      tick();
      tests_run++;
      if ({rd_done, psel} !== 2'b00 || rd_data !== 8'h3C) begin
         tests_failed++; $display("FAIL rd_after: got done/sel=%b%b rd_data=%h, need 00 3c held", rd_done, psel, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int dones;
      dones = 0;
      exp_dir_q = {1'b1, 1'b0, 1'b1, 1'b0};
      exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
      pready = 1'b1; prdata = 8'h5A; wr_ptr = 13'h030; rd_ptr = 13'h031; wr_data = 8'h11;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int cyc = 0; cyc < 40 && dones < 4; cyc++) begin
         tick();
         if (psel && !penable) begin
            tests_run++;
            if (exp_dir_q.size() == 0) begin
               tests_failed++; $display("FAIL b2b_extra_grant: got pwrite=%b, no further grant required", pwrite);
            end else if (pwrite !== exp_dir_q.pop_front()) begin
               tests_failed++; $display("FAIL b2b_grant_order: got pwrite=%b at grant %0d, alternation required", pwrite, dones);
            end
         end
         if (rd_done) begin
            tests_run++;
            if (rd_data !== exp_q.pop_front()) begin
               tests_failed++; $display("FAIL b2b_rd_data: got %h, need 5a", rd_data);
            end
         end
         if (wr_done || rd_done) begin
            dones++;
            if (dones == 4) begin
               wr_req = 1'b0; rd_req = 1'b0;
            end
         end
      end
      tests_run++;
      if (dones != 4 || exp_dir_q.size() != 0) begin
         tests_failed++; $display("FAIL b2b_count: got %0d dones, %0d grants left, need 4 and 0", dones, exp_dir_q.size());
      end
      wr_req = 1'b0; rd_req = 1'b0;
      tick();
      tests_run++;
      if (psel !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_no_duplicate: got psel=%b, need 0", psel);
      end
   endtask

   task automatic test_pslverr();
      pready = 1'b1; pslverr = 1'b1; wr_ptr = 13'h020; wr_data = 8'h77;
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({wr_done, err_pulse} !== 2'b11 || err_status !== 2'b01) begin
         tests_failed++; $display("FAIL pslverr_done: got done/err=%b%b status=%b, need 11 01", wr_done, err_pulse, err_status);
      end
      pslverr = 1'b0;
      tick();
      tests_run++;
      if (err_pulse !== 1'b0 || err_status !== 2'b01) begin
         tests_failed++; $display("FAIL pslverr_sticky: got err=%b status=%b, need 0 01", err_pulse, err_status);
      end
   endtask

   task automatic test_timeout();
      pready = 1'b0; wr_ptr = 13'h040; wr_data = 8'h22;
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if ({psel, penable, wr_done} !== 3'b110) begin
            tests_failed++; $display("FAIL timeout_access_%0d: got sel/en/done=%b%b%b, need 110", i, psel, penable, wr_done);
         end
      end
      err_clr = 1'b1;
      tick();
      tests_run++;
      if ({psel, penable, wr_done, err_pulse} !== 4'b0011 || err_status !== 2'b10) begin
         tests_failed++; $display("FAIL timeout_abort: got sel/en/done/err=%b%b%b%b status=%b, need 0011 10", psel, penable, wr_done, err_pulse, err_status);
      end
      tick();
      err_clr = 1'b0;
      tests_run++;
      if (err_status !== 2'b00 || err_pulse !== 1'b0) begin
         tests_failed++; $display("FAIL err_clr: got status=%b err=%b, need 00 0", err_status, err_pulse);
      end
      pready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_transfer();
      pready = 1'b0; wr_ptr = 13'h050; wr_data = 8'h99;
      wr_req = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({psel, penable} !== 2'b11) begin
         tests_failed++; $display("FAIL rst_pre_access: got sel/en=%b%b, need 11", psel, penable);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({paddr, psel, penable, pwrite, pwdata, busy, wr_done, rd_done, rd_data, err_pulse, err_status} !== '0) begin
         tests_failed++; $display("FAIL rst_async_drop: got paddr=%h sel=%b en=%b busy=%b rd_data=%h, all zero required", paddr, psel, penable, busy, rd_data);
      end
      wr_req = 1'b0;
      tick();
      tests_run++;
      if ({wr_done, err_pulse, psel} !== 3'b000) begin
         tests_failed++; $display("FAIL rst_no_done: got done/err/sel=%b%b%b, need 000", wr_done, err_pulse, psel);
      end
      rst_n = 1'b1;
      pready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_waits();
      test_back_to_back();
      test_pslverr();
      test_timeout();
      test_reset_mid_transfer();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
